// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle between the arbiter and its neighbours: CPU Wishbone slave path, DMA request port, memory controller.
// The slave modport is the arbiter; the master modport is everything around it.
interface wb_mem_arbiter_if #(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32
);
  logic                   wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [pADDR_WIDTH-1:0] wbs_adr_i;
  logic [pDATA_WIDTH-1:0] wbs_dat_i;
  logic                   wbs_ack_o;
  logic [pDATA_WIDTH-1:0] wbs_dat_o;

  logic [pADDR_WIDTH-1:0] dma_addr;
  logic                   dma_rw, dma_out_valid;
  logic [pDATA_WIDTH-1:0] dma_out_data;
  logic                   dma_in_valid;
  logic [pDATA_WIDTH-1:0] dma_in_data;
  logic                   dma_ovf;

  logic                   mem_valid, mem_ready, mem_we;
  logic [3:0]             mem_sel;
  logic [pADDR_WIDTH-1:0] mem_addr;
  logic [pDATA_WIDTH-1:0] mem_wdata;
  logic                   mem_rsp_valid;
  logic [pDATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  dma_addr, dma_rw, dma_out_valid, dma_out_data,
    output dma_in_valid, dma_in_data, dma_ovf,
    output mem_valid, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output dma_addr, dma_rw, dma_out_valid, dma_out_data,
    input  dma_in_valid, dma_in_data, dma_ovf,
    input  mem_valid, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: serialises CPU Wishbone and DMA pulse requests onto one memory controller port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default build gives DMA fixed priority on ties.
module wb_mem_arbiter #(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32
) (
  input logic             axis_clk,
  input logic             axis_rst,
  wb_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  state_t                 state_q;
  logic                   owner_q, abort_q;
  logic                   dma_pend_q, dma_pend_d, dma_ovf_q, dma_ovf_d, dma_cap;
  logic                   dma_rw_q;
  logic [pADDR_WIDTH-1:0] dma_addr_q, mem_addr_q;
  logic [pDATA_WIDTH-1:0] dma_data_q, mem_wdata_q, wbs_dat_q, dma_in_data_q;
  logic                   mem_valid_q, mem_we_q, wbs_ack_q, dma_in_valid_q;
  logic [3:0]             mem_sel_q;
  logic                   cpu_req, grant, dma_win, dma_take;

  assign cpu_req  = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign grant    = (state_q == S_IDLE) & (cpu_req | dma_pend_q);
  assign dma_take = grant & dma_win;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  assign dma_win = dma_pend_q & (~cpu_req | (last_grant_q == OWN_CPU));
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)   last_grant_q <= OWN_CPU;
    else if (grant) last_grant_q <= dma_win;
  end
`else
  assign dma_win = dma_pend_q;
`endif

  // A pulse landing on the grant cycle refills the entry: set beats clear.
  always_comb begin
    dma_pend_d = dma_pend_q;
    dma_ovf_d  = dma_ovf_q;
    dma_cap    = 1'b0;
    if (dma_take) dma_pend_d = 1'b0;
    if (bus.dma_out_valid) begin
      if (!dma_pend_q || dma_take) begin
        dma_cap    = 1'b1;
        dma_pend_d = 1'b1;
      end else begin
        dma_ovf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      dma_pend_q <= 1'b0;
      dma_ovf_q  <= 1'b0;
      dma_rw_q   <= 1'b0;
      dma_addr_q <= '0;
      dma_data_q <= '0;
    end else begin
      dma_pend_q <= dma_pend_d;
      dma_ovf_q  <= dma_ovf_d;
      if (dma_cap) begin
        dma_rw_q   <= bus.dma_rw;
        dma_addr_q <= bus.dma_addr;
        dma_data_q <= bus.dma_out_data;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q        <= S_IDLE;
      owner_q        <= OWN_CPU;
      abort_q        <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_sel_q      <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      wbs_ack_q      <= 1'b0;
      wbs_dat_q      <= '0;
      dma_in_valid_q <= 1'b0;
      dma_in_data_q  <= '0;
    end else begin
      // CPU walking away mid-transaction only suppresses its ack; memory still completes.
      if ((state_q == S_ISSUE || state_q == S_WAIT) && owner_q == OWN_CPU && !bus.wbs_cyc_i)
        abort_q <= 1'b1;
      case (state_q)
        S_IDLE: if (grant) begin
          owner_q     <= dma_win;
          abort_q     <= 1'b0;
          mem_valid_q <= 1'b1;
          if (dma_win) begin
            mem_we_q    <= dma_rw_q;
            mem_sel_q   <= 4'hF;
            mem_addr_q  <= dma_addr_q;
            mem_wdata_q <= dma_data_q;
          end else begin
            mem_we_q    <= bus.wbs_we_i;
            mem_sel_q   <= bus.wbs_sel_i;
            mem_addr_q  <= bus.wbs_adr_i;
            mem_wdata_q <= bus.wbs_dat_i;
          end
          state_q <= S_ISSUE;
        end
        S_ISSUE: if (bus.mem_ready) begin
          mem_valid_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: if (bus.mem_rsp_valid) begin
          if (owner_q == OWN_DMA) begin
            dma_in_valid_q <= 1'b1;
            if (!mem_we_q) dma_in_data_q <= bus.mem_rdata;
          end else begin
            wbs_ack_q <= bus.wbs_cyc_i & ~abort_q;
            if (!mem_we_q) wbs_dat_q <= bus.mem_rdata;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          wbs_ack_q      <= 1'b0;
          dma_in_valid_q <= 1'b0;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wbs_ack_o    = wbs_ack_q;
  assign bus.wbs_dat_o    = wbs_dat_q;
  assign bus.dma_in_valid = dma_in_valid_q;
  assign bus.dma_in_data  = dma_in_data_q;
  assign bus.dma_ovf      = dma_ovf_q;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_sel      = mem_sel_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Single-port arbiter sharing the user-project memory controller between the CPU Wishbone slave path and the DMA engine's request port (addr/rw/out_valid/out_data ↔ in_valid/in_data). It sits between the Wishbone decode, the DMA block and the memory controller, serialises one transaction at a time, and routes each response back to its originator. DMA requests are single-cycle pulses, so the arbiter captures them in a one-entry pending buffer.

## Interface
- pADDR_WIDTH, 32, address width on all ports
- pDATA_WIDTH, 32, data width on all ports

- axis_clk  in  1  clock
- axis_rst  in  1  asynchronous, active-high reset
- wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1  CPU request, already decoded to the memory window
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  pADDR_WIDTH  CPU address
- wbs_dat_i  in  pDATA_WIDTH  CPU write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  pDATA_WIDTH  CPU read data
- dma_addr  in  pADDR_WIDTH  DMA address
- dma_rw  in  1  1 = write, 0 = read
- dma_out_valid  in  1  one-cycle DMA request pulse
- dma_out_data  in  pDATA_WIDTH  DMA write data
- dma_in_valid  out  1  one-cycle completion pulse, for both reads and writes
- dma_in_data  out  pDATA_WIDTH  DMA read data
- mem_valid  out  1  request to the memory controller
- mem_ready  in  1  request accepted
- mem_we  out  1  write enable
- mem_sel  out  4  byte enables; DMA requests always drive 4'hF
- mem_addr  out  pADDR_WIDTH  memory address
- mem_wdata  out  pDATA_WIDTH  memory write data
- mem_rsp_valid  in  1  one-cycle completion pulse from the memory controller
- mem_rdata  in  pDATA_WIDTH  memory read data, valid with mem_rsp_valid
- dma_ovf  out  1  sticky flag: a DMA pulse was dropped

## Operation
- **DMA pending buffer:**
  - A dma_out_valid pulse captures addr/rw/data and sets dma_pend.
  - dma_pend clears on the cycle the DMA request is granted.
  - If a pulse arrives while dma_pend=1 and the entry is not being granted that cycle, the pulse is dropped and dma_ovf is set. dma_ovf clears only on reset.
  - If a pulse arrives on the grant cycle, it is accepted; the set wins over the clear.
- **CPU request:** cpu_req = wbs_cyc_i & wbs_stb_i, sampled only in IDLE.
- **FSM:**
  - IDLE: when cpu_req or dma_pend is set, pick a winner, latch the owner and the request fields into issue registers, then go to ISSUE.
  - ISSUE: hold mem_valid=1 with stable fields until mem_ready=1. On the mem_ready cycle drop mem_valid and go to WAIT.
  - WAIT: on mem_rsp_valid, register mem_rdata and go to RESP.
  - RESP: pulse the owner's response for one cycle, then go to IDLE.
- **Winner selection:**
  - If only one requester is pending, it wins.
  - If both are pending, priority follows Configuration.
- **CPU response:**
  - In RESP, wbs_ack_o=1 only if wbs_cyc_i is still 1.
  - If the CPU dropped cyc during ISSUE or WAIT (abort), the memory transaction still completes and the ack is suppressed.
  - wbs_dat_o holds the last read data.
- **DMA response:** dma_in_valid=1 in RESP; dma_in_data = registered read data (don't-care for writes).
- Only one transaction is outstanding at any time. A mem_rsp_valid outside WAIT is ignored.

## Timing
- **Reset values:**
  - All outputs are 0: wbs_ack_o, wbs_dat_o, dma_in_valid, dma_in_data, mem_valid, mem_we, mem_sel, mem_addr, mem_wdata, dma_ovf.
  - FSM = IDLE, dma_pend=0, last_grant=CPU.
- **Latency:**
  - Request seen in IDLE at cycle N → mem_valid high at N+1.
  - mem_ready at cycle M → WAIT from M+1.
  - mem_rsp_valid at cycle R → ack/in_valid at R+1 → IDLE at R+2.
  - Minimum CPU turnaround, with mem_ready at N+1 and mem_rsp_valid at N+2: ack at N+3.
- A granted requester cannot be re-granted until IDLE is re-entered, so at most one grant is issued every 4 cycles.
- **Reset mid-transaction:** all state is cleared, a pending DMA request is lost, and no response pulses are generated.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, the requester not in last_grant wins; last_grant updates on every grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, DMA always wins a tie; last_grant is not implemented.

## Test plan
- **CPU read:** read 0x3800_0010 with mem_ready immediate and mem_rsp_valid after 2 cycles returning 0xDEADBEEF → wbs_ack_o pulses once, wbs_dat_o=0xDEADBEEF, mem_sel follows wbs_sel_i.
- **DMA writes:** DMA write pulses to 0x3800_0100, 0x104 and 0x108, each issued after the previous dma_in_valid → three memory writes in order with mem_sel=4'hF, three dma_in_valid pulses, dma_ovf=0.
- **Tie handling:**
  - CPU and DMA requests asserted on the same cycle, repeated 4 times → with ARB_ROUND_ROBIN_EN, grants alternate DMA/CPU (last_grant=CPU after reset).
  - Without the macro, DMA wins every tie.
- **Overflow:** second DMA pulse while the first is pending behind a CPU transaction → the second is dropped, dma_ovf=1, and exactly one dma_in_valid pulse occurs.
- **CPU abort:** CPU drops wbs_cyc_i during WAIT → the memory write completes, wbs_ack_o stays 0, and the FSM returns to IDLE and serves a queued DMA request.
- **Reset mid-transaction:** axis_rst asserted during ISSUE with dma_pend=1 → mem_valid=0 immediately, all outputs return to reset values, and no response pulses are generated after release.
